// File: rtl/fp16_pyramid_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pyramid_pkg
// Shared definitions for the FP16 Laplacian-pyramid blocks.
//   - FP16 field widths and the +0.0 bit pattern
//   - fill_mode_e : how the three non-data positions of a 2x2 cell are filled
//   - zie_state_e : sequencing states of the zero-insert expander
// -----------------------------------------------------------------------------
package fp16_pyramid_pkg;

   localparam int FP16_EXP_W  = 5;
   localparam int FP16_FRAC_W = 10;
   localparam int FP16_W      = 1 + FP16_EXP_W + FP16_FRAC_W;

   // +0.0 is all bits clear; -0.0 (sign bit set) is never produced as fill.
   localparam logic [FP16_W-1:0] FP_ZERO = '0;

   typedef enum logic {
      FILL_ZERO      = 1'b0,
      FILL_REPLICATE = 1'b1
   } fill_mode_e;

   typedef enum logic [1:0] {
      EVEN_DATA = 2'd0,
      EVEN_FILL = 2'd1,
      ODD_ROW   = 2'd2
   } zie_state_e;

endpackage

// File: rtl/zero_insert_expander_if.sv
// -----------------------------------------------------------------------------
// zero_insert_expander_if
// Ready/valid pixel stream carrying CHANNELS FP lanes plus grid coordinates.
//   data  : CHANNELS*FPW bits, lane k at [k*FPW +: FPW]
//   col   : 16-bit column coordinate of the beat
//   row   : 16-bit row coordinate of the beat
//   valid : beat present (producer -> consumer)
//   ready : consumer accepts (consumer -> producer)
// master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface zero_insert_expander_if #(
   parameter int CHANNELS = 2,
   parameter int FPW      = 16
);

   logic [CHANNELS*FPW-1:0] data;
   logic [15:0]             col;
   logic [15:0]             row;
   logic                    valid;
   logic                    ready;

   modport master (
      output data,
      output col,
      output row,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  col,
      input  row,
      input  valid,
      output ready
   );

endinterface

// File: rtl/zero_insert_expander_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer_ram
// Simple dual-port RAM holding one input row of pixels.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address, sampled every cycle
//   rdata_o : read data, valid one cycle after raddr_i (synchronous read)
// No reset: every location is written before it is read within a row.
// -----------------------------------------------------------------------------
module line_buffer_ram #(
   parameter int DEPTH  = 4,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 2
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/zero_insert_expander.sv
// -----------------------------------------------------------------------------
// zero_insert_expander
// 2x spatial expander for one pyramid scale. Each input pixel is placed at
// even (row, col) of the output grid; the other three cell positions carry
// +0.0 (FILL_ZERO) or a copy of the pixel (FILL_REPLICATE).
//   clk_i      : clock
//   rst_i      : asynchronous reset, active low
//   mode_i     : fill mode, captured on the first beat of each frame
//   in_bus     : input stream (slave), IN_W x IN_H pixels
//   out_bus    : output stream (master), OUT_W x OUT_H pixels, registered
//   sync_err_o : sticky, set when an accepted beat's coordinate differs from
//                the internally tracked coordinate
// -----------------------------------------------------------------------------
module zero_insert_expander
   import fp16_pyramid_pkg::*;
#(
   parameter int EXP_WIDTH    = 5,
   parameter int FRAC_WIDTH   = 10,
   parameter int CHANNELS     = 2,
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int SCALE        = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   mode_i,
   zero_insert_expander_if.slave  in_bus,
   zero_insert_expander_if.master out_bus,
   output logic                   sync_err_o
);

   localparam int FPW    = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int DW     = CHANNELS * FPW;
   localparam int OUT_W  = IMAGE_WIDTH >> SCALE;
   localparam int OUT_H  = IMAGE_HEIGHT >> SCALE;
   localparam int IN_W   = OUT_W / 2;
   localparam int IN_H   = OUT_H / 2;
   localparam int ADDR_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   localparam logic [15:0] IN_W_LAST  = 16'(IN_W - 1);
   localparam logic [15:0] IN_H_LAST  = 16'(IN_H - 1);
   localparam logic [15:0] OUT_W_LAST = 16'(OUT_W - 1);

   zie_state_e       state_q,    state_d;
   fill_mode_e       mode_q,     mode_d;
   logic [15:0]      in_col_q,   in_col_d;
   logic [15:0]      in_row_q,   in_row_d;
   logic [15:0]      out_col_q,  out_col_d;
   logic [DW-1:0]    held_q,     held_d;
   logic [DW-1:0]    data_q,     data_d;
   logic [15:0]      col_q,      col_d;
   logic [15:0]      row_q,      row_d;
   logic             valid_q,    valid_d;
   logic             sync_err_q, sync_err_d;

   logic             advance;
   logic             ready_int;
   logic             accept;
   logic             lb_we;
   logic [ADDR_W-1:0] lb_waddr;
   logic [ADDR_W-1:0] lb_raddr;
   logic [DW-1:0]    lb_rdata;

   // The output register may load when it is empty or being drained.
   // ready_i only reaches ready_o through this term.
   assign advance   = !valid_q || out_bus.ready;
   assign ready_int = (state_q == EVEN_DATA) && advance;
   assign accept    = in_bus.valid && ready_int;

   // The line buffer read address tracks the column that the output
   // register will load next cycle, so the synchronous read lands just in
   // time. Under stall out_col_d equals out_col_q and the same word is
   // simply read again.
   assign lb_we    = accept;
   assign lb_waddr = ADDR_W'(in_col_q);
   assign lb_raddr = ADDR_W'(out_col_d >> 1);

   // Next-state, counter and output-register computation. Nothing moves
   // while the output register is holding an unaccepted beat.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      in_col_d   = in_col_q;
      in_row_d   = in_row_q;
      out_col_d  = out_col_q;
      held_d     = held_q;
      data_d     = data_q;
      col_d      = col_q;
      row_d      = row_q;
      valid_d    = valid_q;
      sync_err_d = sync_err_q;

      case (state_q)
         EVEN_DATA: begin
            if (accept) begin
               data_d  = in_bus.data;
               held_d  = in_bus.data;
               col_d   = {in_col_q[14:0], 1'b0};
               row_d   = {in_row_q[14:0], 1'b0};
               valid_d = 1'b1;
               // Fill mode is fixed for the whole frame from its first beat.
               if ((in_col_q == 16'd0) && (in_row_q == 16'd0)) begin
                  mode_d = fill_mode_e'(mode_i);
               end
               // Mismatch is flagged but the beat is used at the internal
               // coordinate; no resynchronisation is attempted.
               if ((in_bus.col != in_col_q) || (in_bus.row != in_row_q)) begin
                  sync_err_d = 1'b1;
               end
               state_d = EVEN_FILL;
            end else if (advance) begin
               valid_d = 1'b0;
            end
         end

         EVEN_FILL: begin
            if (advance) begin
               data_d  = (mode_q == FILL_REPLICATE) ? held_q : '0;
               col_d   = {in_col_q[14:0], 1'b1};
               row_d   = {in_row_q[14:0], 1'b0};
               valid_d = 1'b1;
               if (in_col_q == IN_W_LAST) begin
                  out_col_d = 16'd0;
                  state_d   = ODD_ROW;
               end else begin
                  in_col_d = in_col_q + 16'd1;
                  state_d  = EVEN_DATA;
               end
            end
         end

         ODD_ROW: begin
            if (advance) begin
               data_d  = (mode_q == FILL_REPLICATE) ? lb_rdata : '0;
               col_d   = out_col_q;
               row_d   = {in_row_q[14:0], 1'b1};
               valid_d = 1'b1;
               if (out_col_q == OUT_W_LAST) begin
                  out_col_d = 16'd0;
                  in_col_d  = 16'd0;
                  in_row_d  = (in_row_q == IN_H_LAST) ? 16'd0 : in_row_q + 16'd1;
                  state_d   = EVEN_DATA;
               end else begin
                  out_col_d = out_col_q + 16'd1;
               end
            end
         end

         default: begin
            state_d = EVEN_DATA;
         end
      endcase
   end

   // State and registered outputs; reset restarts the frame at (0,0) and
   // drops any beat held in the output register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= EVEN_DATA;
         mode_q     <= FILL_ZERO;
         in_col_q   <= 16'd0;
         in_row_q   <= 16'd0;
         out_col_q  <= 16'd0;
         held_q     <= '0;
         data_q     <= '0;
         col_q      <= 16'd0;
         row_q      <= 16'd0;
         valid_q    <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         in_col_q   <= in_col_d;
         in_row_q   <= in_row_d;
         out_col_q  <= out_col_d;
         held_q     <= held_d;
         data_q     <= data_d;
         col_q      <= col_d;
         row_q      <= row_d;
         valid_q    <= valid_d;
         sync_err_q <= sync_err_d;
      end
   end

   line_buffer_ram #(
      .DEPTH  (IN_W),
      .WIDTH  (DW),
      .ADDR_W (ADDR_W)
   ) u_line_buffer (
      .clk_i   (clk_i),
      .we_i    (lb_we),
      .waddr_i (lb_waddr),
      .wdata_i (in_bus.data),
      .raddr_i (lb_raddr),
      .rdata_o (lb_rdata)
   );

   assign in_bus.ready  = ready_int;
   assign out_bus.data  = data_q;
   assign out_bus.col   = col_q;
   assign out_bus.row   = row_q;
   assign out_bus.valid = valid_q;
   assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_zero_insert_expander.sv
// -----------------------------------------------------------------------------
// tb_zero_insert_expander
// Scoreboard bench for zero_insert_expander on an 8x4 output grid.
// The driver builds each frame's expected output from a cell-level picture of
// the expansion and queues it; an independent monitor pops and compares on
// every output handshake and checks stability while stalled.
// -----------------------------------------------------------------------------
module tb_zero_insert_expander;
   import fp16_pyramid_pkg::*;

   localparam int CHANNELS = 2;
   localparam int FPW      = 16;
   localparam int DW       = CHANNELS * FPW;
   localparam int OUT_W    = 8;
   localparam int OUT_H    = 4;
   localparam int IN_W     = OUT_W / 2;
   localparam int IN_H     = OUT_H / 2;
   localparam int MAX_WAIT = 200;

   typedef struct {
      logic [DW-1:0] data;
      logic [15:0]   col;
      logic [15:0]   row;
   } beat_t;

   logic clk;
   logic rst_i;
   logic mode_i;
   logic sync_err_o;

   zero_insert_expander_if #(.CHANNELS(CHANNELS), .FPW(FPW)) in_if ();
   zero_insert_expander_if #(.CHANNELS(CHANNELS), .FPW(FPW)) out_if ();

   zero_insert_expander #(
      .EXP_WIDTH    (5),
      .FRAC_WIDTH   (10),
      .CHANNELS     (CHANNELS),
      .IMAGE_WIDTH  (OUT_W),
      .IMAGE_HEIGHT (OUT_H),
      .SCALE        (0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .mode_i     (mode_i),
      .in_bus     (in_if),
      .out_bus    (out_if),
      .sync_err_o (sync_err_o)
   );

   int    errors = 0;
   int    checks = 0;
   beat_t expQ[$];
   logic [DW-1:0] pix [IN_H][IN_W];
   int    readyMode = 0;
   int    readyPhase = 0;
   logic [3:0] readyPattern = 4'b1001;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared comparison helper used by the driver and the monitor.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready: always high, the 1,0,0,1 pattern, or random.
   initial begin
      out_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            1: begin
               out_if.ready = readyPattern[3 - (readyPhase % 4)];
               readyPhase++;
            end
            2: out_if.ready = 1'($urandom_range(0, 1));
            default: out_if.ready = 1'b1;
         endcase
      end
   end

   // Monitor: sampled on the falling edge, half a cycle from any change.
   logic          stalled = 1'b0;
   logic [63:0]   savedOut;
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst_i) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checkOutput("stall_hold", {out_if.data, out_if.col[14:0], out_if.row[14:0], 1'b0, out_if.valid},
                           savedOut);
            end
            if (out_if.valid && out_if.ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", {out_if.col, out_if.row}, 64'hffff_ffff);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat_data", 64'(out_if.data), 64'(e.data));
                  checkOutput("beat_coord", {32'd0, out_if.col, out_if.row}, {32'd0, e.col, e.row});
               end
            end
            stalled  = out_if.valid && !out_if.ready;
            savedOut = {out_if.data, out_if.col[14:0], out_if.row[14:0], 1'b0, out_if.valid};
         end
      end
   end

   // Drive one frame (or its first rowsToSend rows). Expected output for the
   // whole frame is queued up front: every output cell (R,C) comes from input
   // pixel (R/2,C/2); only the top-left position of each 2x2 cell carries it
   // in zero mode, all four do in replicate mode.
   task automatic applyStimulus(input int frameMode, input int flipMode, input bit planData,
                                input int badIdx, input int rowsToSend);
      beat_t e;
      int    waited;
      bit    got;
      logic [15:0] plan0 [IN_W];
      plan0[0] = 16'h3c00; plan0[1] = 16'h4000; plan0[2] = 16'h4200; plan0[3] = 16'h4400;

      for (int r = 0; r < IN_H; r++) begin
         for (int c = 0; c < IN_W; c++) begin
            if (planData && r == 0) pix[r][c] = {16'hbc00 + 16'(c), plan0[c]};
            else                    pix[r][c] = DW'($urandom);
         end
      end

      for (int rr = 0; rr < OUT_H; rr++) begin
         for (int cc = 0; cc < OUT_W; cc++) begin
            e.col = 16'(cc);
            e.row = 16'(rr);
            if ((rr % 2 == 0 && cc % 2 == 0) || frameMode == 1) e.data = pix[rr / 2][cc / 2];
            else                                                e.data = {CHANNELS{FP_ZERO}};
            expQ.push_back(e);
         end
      end

      @(posedge clk);
      #1;
      mode_i = 1'(frameMode);
      for (int r = 0; r < rowsToSend; r++) begin
         for (int c = 0; c < IN_W; c++) begin
            in_if.data  = pix[r][c];
            in_if.col   = (r * IN_W + c == badIdx) ? 16'd3 : 16'(c);
            in_if.row   = 16'(r);
            in_if.valid = 1'b1;
            waited = 0;
            forever begin
               @(negedge clk);
               got = in_if.ready;
               if (got && r * IN_W + c == badIdx) checkOutput("sync_err_before", 64'(sync_err_o), 64'd0);
               @(posedge clk);
               #1;
               if (got) break;
               waited++;
               if (waited > MAX_WAIT) begin
                  checkOutput("input_accept_timeout", 64'(waited), 64'd0);
                  break;
               end
            end
            if (r * IN_W + c == badIdx) checkOutput("sync_err_after", 64'(sync_err_o), 64'd1);
            if (r == 0 && c == 0 && flipMode >= 0) mode_i = 1'(flipMode);
         end
      end
      in_if.valid = 1'b0;
   endtask

   // Wait for the scoreboard to empty, bounded.
   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 64'(expQ.size()), 64'd0);
   endtask

   // Watchdog.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rst_i       = 1'b0;
      mode_i      = 1'b0;
      in_if.valid = 1'b0;
      in_if.data  = '0;
      in_if.col   = 16'd0;
      in_if.row   = 16'd0;
      #12;
      checkOutput("reset_valid",    64'(out_if.valid), 64'd0);
      checkOutput("reset_data",     64'(out_if.data),  64'd0);
      checkOutput("reset_coord",    {32'd0, out_if.col, out_if.row}, 64'd0);
      checkOutput("reset_ready",    64'(in_if.ready),  64'd1);
      checkOutput("reset_sync_err", 64'(sync_err_o),   64'd0);
      @(negedge clk);
      rst_i = 1'b1;

      // Plan data, zero fill then replicate, no backpressure.
      applyStimulus(0, -1, 1'b1, -1, IN_H);
      waitDrain();
      applyStimulus(1, -1, 1'b1, -1, IN_H);
      waitDrain();

      // 1,0,0,1 backpressure, then random backpressure.
      readyMode = 1;
      applyStimulus(0, -1, 1'b1, -1, IN_H);
      applyStimulus(1, -1, 1'b0, -1, IN_H);
      waitDrain();
      readyMode = 2;
      applyStimulus(int'($urandom_range(0, 1)), -1, 1'b0, -1, IN_H);
      applyStimulus(1, -1, 1'b0, -1, IN_H);
      waitDrain();

      // Mode flipped after the first beat: this frame zero, next replicate.
      readyMode = 0;
      applyStimulus(0, 1, 1'b0, -1, IN_H);
      applyStimulus(1, -1, 1'b0, -1, IN_H);
      waitDrain();
      checkOutput("sync_err_clean", 64'(sync_err_o), 64'd0);

      // Coordinate mismatch on beat (row 0, col 1).
      applyStimulus(0, -1, 1'b0, 1, IN_H);
      waitDrain();
      checkOutput("sync_err_sticky", 64'(sync_err_o), 64'd1);

      // Reset while the odd fill row is streaming.
      applyStimulus(1, -1, 1'b0, -1, 1);
      n = 0;
      while (!(out_if.valid && out_if.row == 16'd1) && n < MAX_WAIT) begin
         @(negedge clk);
         n++;
      end
      checkOutput("odd_row_reached", 64'(n < MAX_WAIT), 64'd1);
      @(posedge clk);
      #2;
      rst_i = 1'b0;
      #1;
      expQ.delete();
      checkOutput("midrst_valid",    64'(out_if.valid), 64'd0);
      checkOutput("midrst_data",     64'(out_if.data),  64'd0);
      checkOutput("midrst_coord",    {32'd0, out_if.col, out_if.row}, 64'd0);
      checkOutput("midrst_sync_err", 64'(sync_err_o),   64'd0);
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      checkOutput("midrst_ready", 64'(in_if.ready), 64'd1);
      checkOutput("midrst_no_residual_valid", 64'(out_if.valid), 64'd0);

      // Fresh frame after reset must start at (0,0).
      applyStimulus(1, -1, 1'b0, -1, IN_H);
      waitDrain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zero_insert_expander.md
# zero_insert_expander

Parametrised 2x expander for the FP16 Laplacian-pyramid scales. It takes a downsampled multi-channel pixel stream of (IMAGE_WIDTH>>SCALE)/2 × (IMAGE_HEIGHT>>SCALE)/2 and emits the full scale-resolution stream, placing the 3×3 upsampler window fetcher downstream. Each input pixel lands at even (row, col). The other three positions are filled either with +0.0 (zero-insert) or with a copy of that pixel (nearest-neighbour replicate). Unlike the fixed single-channel zero inserter, it adds CHANNELS, a runtime fill mode, ready/valid backpressure and coordinate checking.

## Interface
- EXP_WIDTH, 5, FP exponent bits
- FRAC_WIDTH, 10, FP fraction bits
- CHANNELS, 2, parallel FP lanes (e.g. I_A and I_T)
- IMAGE_WIDTH, 640, scale-0 width; (IMAGE_WIDTH>>SCALE) must be even
- IMAGE_HEIGHT, 480, scale-0 height; (IMAGE_HEIGHT>>SCALE) must be even
- SCALE, 0, pyramid scale; OUT_W = IMAGE_WIDTH>>SCALE, OUT_H = IMAGE_HEIGHT>>SCALE, IN_W = OUT_W/2, IN_H = OUT_H/2
- clk_i  in  1  sole clock
- rst_i  in  1  reset, asynchronous, active-low
- mode_i  in  1  0 = zero-insert, 1 = replicate; sampled at frame start only
- data_i  in  CHANNELS×(1+EXP_WIDTH+FRAC_WIDTH)  input pixel, lane k at bits [k*FPW +: FPW]
- col_i, row_i  in  16 each  input-grid coordinate of data_i
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_o  out  CHANNELS×FPW  output pixel
- col_o, row_o  out  16 each  output-grid coordinate
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts when valid_o && ready_i
- sync_err_o  out  1  sticky: an accepted col_i/row_i differed from the internal expected coordinate

## Operation
- States: EVEN_DATA (wait for input), EVEN_FILL (emit odd-column fill), ODD_ROW (emit fill row, no input).
- Internal counters: in_col (0..IN_W-1), in_row (0..IN_H-1), out_col (0..OUT_W-1).
- EVEN_DATA: accepts a beat, emits data_i at (2·in_row, 2·in_col), writes data_i to line buffer[in_col] → EVEN_FILL.
- EVEN_FILL: emits fill at (2·in_row, 2·in_col+1). Fill is all-zero (+0.0 per lane) in zero mode and the held pixel in replicate mode. Then: if in_col == IN_W-1 → ODD_ROW with out_col=0, else in_col++ → EVEN_DATA.
- ODD_ROW: emits OUT_W beats at row 2·in_row+1, col = out_col. Data is zero, or line buffer[out_col>>1] in replicate mode. After the beat with out_col == OUT_W-1: in_col=0, in_row++ (wrap to 0 after IN_H-1) → EVEN_DATA.
- Frame start = EVEN_DATA with in_row==0 && in_col==0. mode_i is latched into mode_q on the accepted beat there and held for the whole frame.
- Coordinate check on every accepted beat: (col_i,row_i) ≠ (in_col,in_row) sets sync_err_o. The beat is still processed at the internal coordinate; no resync occurs. sync_err_o clears only on reset.
- FP zero is +0.0 (all bits 0), never −0.0.

## Timing
- Reset (rst_i low, async): state=EVEN_DATA, counters 0, mode_q=0, data_o=0, col_o=0, row_o=0, valid_o=0, sync_err_o=0. ready_o evaluates to 1. Line buffer is not cleared, because it is always written before it is read.
- Output is a registered stage. The first output beat is valid the cycle after input acceptance (latency 1).
- ready_o = (state==EVEN_DATA) && (!valid_o || ready_i). This is the only combinational path from ready_i.
- While valid_o && !ready_i: data_o, col_o, row_o and valid_o are held stable, and state and counters freeze.
- Throughput with ready_i=1: one input every 2 cycles on even rows, and ready_o low for OUT_W cycles per odd row. One frame = OUT_W·OUT_H output cycles.
- The line buffer has a synchronous read. ODD_ROW reads are issued one cycle ahead of the output register load, including under stall.
- Reset mid-frame: the frame restarts at (0,0). The partial frame is dropped, and no residual valid_o appears after release.

## Structure
- Shared package fp16_pyramid_pkg: fill_mode_e (FILL_ZERO, FILL_REPLICATE), zie_state_e, FP16 widths, FP_ZERO constant.
- Sub-module line_buffer_ram: simple dual-port, DEPTH=IN_W, WIDTH=CHANNELS×FPW, 1-cycle read latency. It is used only in replicate mode but is always instantiated.

## Test plan
- IMAGE 8×4, SCALE 0, mode 0, lane0 input row0 = 3c00,4000,4200,4400 → out row0 = 3c00,0000,4000,0000,4200,0000,4400,0000; row1 = eight 0000; total 32 beats; sync_err_o=0.
- Same stimulus, mode 1 → row0 = 3c00,3c00,4000,4000,4200,4200,4400,4400; row1 identical to row0; lane1 independent (e.g. bc00 replicated).
- ready_i toggling 1,0,0,1 repeatedly → output sequence identical to the unstalled run, with no beat lost or duplicated and data stable while stalled.
- mode_i flipped 0→1 mid-frame → current frame stays zero-fill; next frame (first beat at 0,0) replicates.
- Input beat sent with col_i=3 when 1 is expected → sync_err_o rises the cycle after acceptance and stays 1; output coordinates follow internal count.
- rst_i pulsed low during ODD_ROW → all outputs 0 immediately, ready_o=1 after release; next frame's output starts at (0,0).
